tapped_delay_line: RTL
======================

Name: tapped_delay_line

Overview:
- Parametrised delay line: WIDTH-bit data passes through DEPTH register stages.
- A run-time selector picks the output tap, giving 0..DEPTH cycles of delay.
- Adds features the fixed 3-stage version lacks: clock enable (stall), synchronous flush, per-stage valid tracking and a fill counter.
- Used wherever a datapath needs a programmable alignment delay.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 3, number of register stages and maximum delay in cycles (>=1).
- SEL_W, $clog2(DEPTH+1), width of sel and fill. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  shift enable; when 0, all stages hold.
- flush  input  1  synchronous clear of stage data and valid bits.
- in_valid  input  1  qualifies d.
- d  input  WIDTH  input data.
- sel  input  SEL_W  tap select: 0 = bypass, k = k-cycle delay.
- q  output  WIDTH  selected tap data.
- q_valid  output  1  selected tap valid.
- fill  output  SEL_W  enabled shifts since last rst/flush, saturating at DEPTH.

Behaviour:
- State:
  - stage[0..DEPTH-1] (WIDTH bits each)
  - vld[0..DEPTH-1]
  - fill counter
- Reset (rst=1 at a clock edge):
  - all stage[i] = 0, all vld[i] = 0, fill = 0.
  - q/q_valid then follow the mux rules below, e.g. sel=2 gives q=0, q_valid=0.
- Priority at a clock edge: rst > flush > en.
- flush=1 (rst=0): same clearing as reset, regardless of en. Input d/in_valid on that cycle is dropped.
- en=1 (rst=0, flush=0):
  - stage[0] <= d, vld[0] <= in_valid.
  - stage[i] <= stage[i-1], vld[i] <= vld[i-1] for i = 1..DEPTH-1.
  - fill <= min(fill+1, DEPTH).
- en=0 (rst=0, flush=0): stages, vld and fill hold. Data with in_valid=1 in that cycle is not captured.
- Output mux (combinational, no added latency):
  - sel=0: q=d, q_valid=in_valid (pure bypass, active even during stall).
  - 1<=sel<=DEPTH: q=stage[sel-1], q_valid=vld[sel-1].
  - sel>DEPTH (unencodable tap): q=0, q_valid=0.
- Delay counts enabled cycles, not clock cycles: a word on d at an enabled edge appears at tap k after k enabled edges.
- Changing sel mid-stream is glitch-free at the register level: the output switches immediately to the new tap's contents. No data is reordered or lost inside the stages.
- fill saturates: it stays at DEPTH on further enabled shifts and never wraps.
- fill counts enabled edges, not valid words (in_valid=0 shifts still increment it).
- rst or flush mid-stream discards all in-flight words. The first valid output after that is the first word shifted in afterwards.
- A bubble (in_valid=0) propagates through the stages as vld=0, and its data is still shifted.

Test Plan:
- WIDTH=8, DEPTH=3, rst then sel=3, en=1, in_valid=1, d=0x11,0x22,0x33,0x44 on consecutive edges -> q_valid=0 until the third edge. After the 3rd edge q=0x11; after the 4th edge q=0x22. fill goes 1,2,3,3.
- sel=0, en=0, d=0xA5, in_valid=1 -> q=0xA5, q_valid=1 the same cycle. Stage contents and fill unchanged after the edge.
- Pipeline full with 0x11,0x22,0x33 (stage[2..0]); sweep sel 1,2,3 without clocking -> q=0x33, 0x22, 0x11 respectively. Then stall en=0 for 5 edges: values unchanged.
- Shift 0x01 (valid), 0x02 (in_valid=0), 0x03 (valid) with sel=2 -> after edge 2 q=0x01, q_valid=1. After edge 3 q=0x02, q_valid=0. After edge 4 q=0x03, q_valid=1.
- Full pipeline, assert flush=1 together with en=1, d=0x77 -> next cycle all taps q=0, q_valid=0, fill=0, and 0x77 is absent at every tap. Repeat with rst=1 and flush=0: same result.
- Param sweep WIDTH=16, DEPTH=8 (SEL_W=4): sel=8 gives delay of 8 enabled edges for 0xBEEF. sel=9..15 gives q=0, q_valid=0. fill saturates at 8 after 20 shifts.

Source files
------------

// File: rtl/tapped_delay_line.sv
// tapped_delay_line: programmable alignment delay of 0..DEPTH enabled cycles.
// WIDTH-bit data moves through DEPTH register stages. Each stage carries a
// valid bit. A run-time tap select picks which stage drives the output.
// The line supports stall (en), synchronous flush and a saturating fill count.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset; clears stages, valids and fill
//   en       shift enable; 0 holds every stage
//   flush    synchronous clear, same effect as rst; drops this cycle's input
//   in_valid qualifies d
//   d        input data
//   sel      tap select: 0 = bypass, k = k-enabled-cycle delay, >DEPTH = zero
//   q        selected tap data (combinational)
//   q_valid  selected tap valid (combinational)
//   fill     enabled shifts since last rst/flush, saturating at DEPTH
module tapped_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned SEL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [SEL_W-1:0] fill
);

    localparam logic [SEL_W-1:0] FILL_MAX = SEL_W'(DEPTH);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [SEL_W-1:0] fill_q;
    logic [SEL_W-1:0] fill_d;

    // Next-state: flush clears, en shifts, otherwise everything holds.
    always_comb begin
        stage_d = stage_q;
        vld_d   = vld_q;
        fill_d  = fill_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
            vld_d  = '0;
            fill_d = '0;
        end else if (en) begin
            stage_d[0] = d;
            vld_d[0]   = in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
                vld_d[i]   = vld_q[i-1];
            end
            // Fill counts enabled edges and sticks at DEPTH.
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + SEL_W'(1);
            end
        end
    end

    // State registers; reset takes priority over flush and en.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            vld_q  <= '0;
            fill_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            vld_q  <= vld_d;
            fill_q <= fill_d;
        end
    end

    // Output tap mux. sel=0 bypasses the line, and unencodable taps read as zero.
    always_comb begin
        q       = '0;
        q_valid = 1'b0;
        if (sel == '0) begin
            q       = d;
            q_valid = in_valid;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sel == SEL_W'(i + 1)) begin
                    q       = stage_q[i];
                    q_valid = vld_q[i];
                end
            end
        end
    end

    assign fill = fill_q;

endmodule
